fetch_stage: RTL and testbench

Fetch stage of the 32-bit, four-stage processor pipeline, sitting directly upstream of the decode stage. It owns the program counter and issues word fetches to instruction memory over a request/response handshake. It buffers returned instructions in a small in-order queue and presents them, with their PC, to decode under a downstream stall. A taken-branch redirect from the execute stage flushes the queue and discards every in-flight response.

---
 rtl/fetch_stage_if.sv | 11 +
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input ready, rvalid, rdata);
    modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues in-order word fetches and buffers returned
// instructions in a small queue for decode; a redirect flushes everything in flight.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IBUF_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_stage_if.master      imem,
    input  logic               redirect_valid_i,
    input  logic [31:0]        redirect_pc_i,
    input  logic               dec_stall_i,
    output logic               instr_valid_o,
    output logic [31:0]        instruction_o,
    output logic [31:0]        pc_out_o
);
    localparam int PW = $clog2(IBUF_DEPTH);
    localparam int CW = $clog2(IBUF_DEPTH + 1);
    typedef logic [CW-1:0] cnt_t;

    logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    cnt_t          outst_q, outst_d, drop_q, drop_d, count_q, count_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [31:0]   pc_mem_q    [IBUF_DEPTH];
    logic [31:0]   instr_mem_q [IBUF_DEPTH];

    logic          pop, rsp, push, accept;
    logic [CW:0]   credit;

    always_comb begin
        instr_valid_o = (count_q != '0);
        pop           = instr_valid_o && !dec_stall_i;
        // Every slot either queued or owed by memory counts against the queue.
        credit        = {1'b0, outst_q} + {1'b0, count_q} - (CW+1)'(pop);
        imem.req      = rst_n && !redirect_valid_i && (credit < (CW+1)'(IBUF_DEPTH));
        imem.addr     = fetch_pc_q;
        instruction_o = instr_valid_o ? instr_mem_q[rptr_q] : 32'h0;
        pc_out_o      = instr_valid_o ? pc_mem_q[rptr_q]    : 32'h0;

        accept = imem.req && imem.ready;
        rsp    = imem.rvalid && (outst_q != '0);
        push   = rsp && (drop_q == '0) && !redirect_valid_i;

        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;

        if (redirect_valid_i) begin
            fetch_pc_d = redirect_pc_i;
            resp_pc_d  = redirect_pc_i;
            // Every response still owed belongs to the old path, including ones already marked.
            drop_d     = outst_q - cnt_t'(rsp);
            outst_d    = outst_q - cnt_t'(rsp);
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
            outst_d = outst_q + cnt_t'(accept) - cnt_t'(rsp);
            if (rsp && (drop_q != '0)) drop_d = drop_q - cnt_t'(1);
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wptr_d    = wptr_q + PW'(1);
            end
            if (pop) rptr_d = rptr_q + PW'(1);
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            pc_mem_q[wptr_q]    <= resp_pc_q;
            instr_mem_q[wptr_q] <= imem.rdata;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-programmable memory model plus an in-order scoreboard of decode results.
module tb_fetch_stage;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        dec_stall = 1'b0;
    logic        instr_valid, w_iv;
    logic [31:0] instruction, pc_out, w_instr, w_pc;

    fetch_stage_if mif();
    fetch_stage_if wif();

    fetch_stage #(.RESET_PC(32'h0), .IBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .imem(mif.master),
        .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc), .dec_stall_i(dec_stall),
        .instr_valid_o(instr_valid), .instruction_o(instruction), .pc_out_o(pc_out));

    fetch_stage #(.RESET_PC(WRAP_PC), .IBUF_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem(wif.master),
        .redirect_valid_i(1'b0), .redirect_pc_i(32'h0), .dec_stall_i(1'b0),
        .instr_valid_o(w_iv), .instruction_o(w_instr), .pc_out_o(w_pc));

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memf(logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    typedef struct { int due; logic [31:0] data; } rsp_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
    rsp_t pend[$];
    exp_t sb[$];

    int          cyc = 0, lat = 1, rel_cyc = 0;
    bit          rand_ready = 1'b0, chk_nv = 1'b0;
    logic [31:0] exp_fetch = 32'h0, exp_dec = 32'h0;
    int          first_acc = -1, first_val = -1, redir_cyc = -1, redir_first = -1;
    int          w_nacc = 0, w_nval = 0;

    // One clock: observe at the falling edge, drive memory just after the rising edge.
    task automatic cycle();
        bit   acc, pop;
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            acc = mif.req && mif.ready;
            pop = instr_valid && !dec_stall && !redirect_valid;
            if (chk_nv) begin
                chk("redir_next_invalid", instr_valid, 0);
                chk_nv = 1'b0;
            end
            if (!instr_valid) begin
                chk("idle_instr_zero", instruction, 32'h0);
                chk("idle_pc_zero", pc_out, 32'h0);
            end
            if (instr_valid && first_val < 0) first_val = cyc;
            if (instr_valid && redir_cyc >= 0 && redir_first < 0) redir_first = cyc;
            if (pop) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("dec_pc", pc_out, e.pc);
                    chk("dec_instr", instruction, e.ins);
                end
                chk("dec_seq", pc_out, exp_dec);
                exp_dec += 32'd4;
            end
            if (redirect_valid) begin
                chk("redir_no_req", mif.req, 0);
                sb.delete();
                exp_fetch   = redirect_pc;
                exp_dec     = redirect_pc;
                chk_nv      = 1'b1;
                redir_cyc   = cyc;
                redir_first = -1;
            end else if (acc) begin
                chk("fetch_addr", mif.addr, exp_fetch);
                pend.push_back('{cyc + lat, memf(mif.addr)});
                sb.push_back('{mif.addr, memf(mif.addr)});
                exp_fetch += 32'd4;
                if (first_acc < 0) first_acc = cyc;
            end
        end else begin
            pend.delete();
            sb.delete();
        end
        @(posedge clk);
        cyc++;
        #1;
        redirect_valid = 1'b0;
        if (rst_n && pend.size() != 0 && pend[0].due == cyc) begin
            mif.rvalid = 1'b1;
            mif.rdata  = pend[0].data;
            pend.delete(0);
        end else begin
            mif.rvalid = 1'b0;
            mif.rdata  = 32'h0;
        end
        mif.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        chk("rst_req", mif.req, 0);
        chk("rst_addr", mif.addr, 32'h0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        cycle();
        rst_n     = 1'b1;
        rel_cyc   = cyc;
        exp_fetch = 32'h0;
        exp_dec   = 32'h0;
        first_acc = -1;
        first_val = -1;
        redir_cyc = -1;
    endtask

    // Second instance: RESET_PC near the top of the address space, L = 1, never stalled.
    initial begin
        bit          acc;
        logic [31:0] a;
        logic [31:0] wexp, wpc;
        wexp = WRAP_PC;
        wpc  = WRAP_PC;
        wif.ready = 1'b1; wif.rvalid = 1'b0; wif.rdata = 32'h0;
        forever begin
            @(negedge clk);
            acc = rst_n && wif.req && wif.ready;
            a   = wif.addr;
            if (acc && w_nacc < 6) begin
                chk("wrap_addr", a, wexp);
                wexp += 32'd4;
                w_nacc++;
            end
            if (rst_n && w_iv && w_nval < 6) begin
                chk("wrap_pc", w_pc, wpc);
                chk("wrap_instr", w_instr, memf(wpc));
                wpc += 32'd4;
                w_nval++;
            end
            @(posedge clk);
            #1;
            wif.rvalid = acc;
            wif.rdata  = memf(a);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nv, k;
        logic [31:0] held_pc, held_ins;
        mif.ready = 1'b1; mif.rvalid = 1'b0; mif.rdata = 32'h0;

        // Streaming at L = 1
        lat = 1;
        do_reset();
        repeat (6) cycle();
        chk("first_fetch_cycle", first_acc - rel_cyc, 0);
        chk("fetch_to_dec_lat", first_val - first_acc, 2);
        nv = 0;
        repeat (20) begin cycle(); nv += int'(instr_valid); end
        chk("throughput", nv, 20);

        // Stall for 10 cycles
        held_pc  = pc_out;
        held_ins = instruction;
        dec_stall = 1'b1;
        repeat (10) begin
            cycle();
            chk("stall_pc", pc_out, held_pc);
            chk("stall_instr", instruction, held_ins);
            chk("stall_credit", sb.size() <= DEPTH, 1);
        end
        #1 chk("stall_full_no_req", mif.req, 0);
        dec_stall = 1'b0;
        nv = 0;
        repeat (8) begin cycle(); nv += int'(instr_valid); end
        chk("stall_release_nogap", nv, 8);

        // Redirect coinciding with a response and a head entry
        k = 0;
        while (!(mif.rvalid && instr_valid) && k < 20) begin cycle(); k++; end
        chk("redir_setup", k < 20, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cycle();
        #1;
        chk("redir_req_next", mif.req, 1);
        chk("redir_addr_next", mif.addr, 32'h200);
        repeat (6) cycle();
        chk("redir_lat", (redir_first >= 0) && (redir_first - redir_cyc >= 3), 1);

        // L = 3, redirect with three requests in flight
        lat = 3;
        k = 0;
        while ((pend.size() + int'(mif.rvalid)) < 3 && k < 20) begin cycle(); k++; end
        chk("l3_inflight", k < 20, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cycle();
        repeat (14) cycle();
        chk("l3_resumed", exp_dec > 32'h100, 1);

        // Random ready and stalls at L = 2
        lat = 2;
        rand_ready = 1'b1;
        repeat (40) begin
            dec_stall = ($urandom_range(0, 3) == 0);
            cycle();
        end
        dec_stall  = 1'b0;
        rand_ready = 1'b0;
        repeat (12) cycle();

        // Mid-stream reset with two requests outstanding
        lat = 3;
        k = 0;
        while ((pend.size() + int'(mif.rvalid)) < 2 && k < 20) begin cycle(); k++; end
        chk("rst_inflight", k < 20, 1);
        do_reset();
        repeat (12) cycle();
        chk("restart_first_fetch", first_acc - rel_cyc, 0);
        chk("restart_decoded", exp_dec > 32'h0, 1);

        chk("wrap_fetches_seen", w_nacc, 6);
        chk("wrap_decodes_seen", w_nval, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
